// File: rtl/fifo_rd_stream_adapter_if.sv
// Stream-side bundle of the FIFO read adapter: FIFO pull port, flush, and the
// valid/ready output stream with occupancy and transfer count.
interface fifo_rd_stream_adapter_if #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned CSIZE = 16
);
  logic             fifo_empty;
  logic [DSIZE-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             in_flush;
  logic             out_ready;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic [1:0]       out_occ;
  logic [CSIZE-1:0] out_count;

  modport master (
    input  fifo_empty, fifo_data, in_flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_occ, out_count
  );

  modport slave (
    output fifo_empty, fifo_data, in_flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_occ, out_count
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Converts the async FIFO's read port (rd_en, data one cycle later) into a
// valid/ready stream through a 2-entry skid buffer, with flush and word counter.
module fifo_rd_stream_adapter #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned CSIZE = 16
) (
  input logic                       rdclk,
  input logic                       in_resetn,
  fifo_rd_stream_adapter_if.master  bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e             occ_q;
  logic             inflight_q;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic [CSIZE-1:0] count_q;

  logic       pop;
  logic       rd_en;
  logic [1:0] fill;

  assign pop = (occ_q != StEmpty) & bus.out_ready;

  // Occupancy after this cycle's pop and landing word; never exceeds 2.
  assign fill  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_en = in_resetn & ~bus.fifo_empty & ~bus.in_flush & (fill < 2'd2);

  always_ff @(posedge rdclk or negedge in_resetn) begin
    if (!in_resetn) begin
      occ_q      <= StEmpty;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= rd_en;
      if (pop) begin
        count_q <= count_q + CSIZE'(1);
      end
      // Flush drops buffered words and the word landing this cycle.
      if (bus.in_flush) begin
        occ_q <= StEmpty;
      end else begin
        unique case (occ_q)
          StEmpty: begin
            if (inflight_q) begin
              head_q <= bus.fifo_data;
              occ_q  <= StOne;
            end
          end
          StOne: begin
            if (inflight_q) begin
              if (pop) begin
                head_q <= bus.fifo_data;
              end else begin
                tail_q <= bus.fifo_data;
                occ_q  <= StTwo;
              end
            end else if (pop) begin
              occ_q <= StEmpty;
            end
          end
          StTwo: begin
            if (pop) begin
              head_q <= tail_q;
              if (inflight_q) begin
                tail_q <= bus.fifo_data;
              end else begin
                occ_q <= StOne;
              end
            end
          end
          default: occ_q <= StEmpty;
        endcase
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (occ_q != StEmpty);
  assign bus.out_data   = head_q;
  assign bus.out_occ    = occ_q;
  assign bus.out_count  = count_q;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench: a FIFO model feeds random words, a monitor tracks words
// read-but-not-consumed in a queue and checks every stream output each cycle.
module tb_fifo_rd_stream_adapter;
  localparam int unsigned DSIZE = 32;
  localparam int unsigned CSIZE = 4;
  localparam int          MEM   = 4096;

  logic rdclk = 1'b0;
  logic in_resetn;

  fifo_rd_stream_adapter_if #(.DSIZE(DSIZE), .CSIZE(CSIZE)) bus ();

  fifo_rd_stream_adapter #(.DSIZE(DSIZE), .CSIZE(CSIZE)) dut (
    .rdclk     (rdclk),
    .in_resetn (in_resetn),
    .bus       (bus)
  );

  always #5 rdclk = ~rdclk;

  logic [DSIZE-1:0] src_mem [MEM];
  int               pushed_cnt = 0;
  int               popped_cnt = 0;
  int               n_vec = 0;
  int               n_err = 0;
  logic [DSIZE-1:0] exp_q [$];
  logic [CSIZE-1:0] exp_count;
  bit               infl;

  assign bus.fifo_empty = (pushed_cnt == popped_cnt);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] w);
    src_mem[pushed_cnt % MEM] = w;
    pushed_cnt++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge rdclk);
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge rdclk);
      if (popped_cnt == pushed_cnt && !bus.out_valid) break;
    end
    cycles(3);
    #3;
    check({name, "_all_read"}, 64'(popped_cnt), 64'(pushed_cnt));
    check({name, "_occ"}, 64'(bus.out_occ), 64'd0);
  endtask

  // FIFO model + scoreboard monitor, sampling 2 time units before each rising edge.
  initial begin
    int               occ_m;
    bit               pop;
    bit               want_rd;
    bit               rd;
    logic [DSIZE-1:0] w;
    bus.fifo_data = '0;
    exp_count     = '0;
    infl          = 1'b0;
    w             = '0;
    forever begin
      @(negedge rdclk);
      #3;
      if (!in_resetn) begin
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_occ", 64'(bus.out_occ), 64'd0);
        check("rst_count", 64'(bus.out_count), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        exp_q.delete();
        infl      = 1'b0;
        exp_count = '0;
        @(posedge rdclk);
        bus.fifo_data <= DSIZE'($urandom);
      end else begin
        occ_m = exp_q.size() - int'(infl);
        check("occ", 64'(bus.out_occ), 64'(occ_m));
        check("valid", 64'(bus.out_valid), 64'(occ_m != 0));
        check("count", 64'(bus.out_count), 64'(exp_count));
        if (occ_m != 0) check("data", 64'(bus.out_data), 64'(exp_q[0]));
        check("rd_while_empty", 64'(bus.fifo_rd_en & bus.fifo_empty), 64'd0);
        pop = (occ_m != 0) && bus.out_ready;
        if (pop) begin
          void'(exp_q.pop_front());
          exp_count++;
        end
        want_rd = !bus.fifo_empty && !bus.in_flush && (exp_q.size() < 2);
        check("rd_en", 64'(bus.fifo_rd_en), 64'(want_rd));
        if (bus.in_flush) exp_q.delete();
        rd = bus.fifo_rd_en && !bus.fifo_empty;
        if (rd) begin
          w = src_mem[popped_cnt % MEM];
          exp_q.push_back(w);
        end
        infl = rd;
        @(posedge rdclk);
        if (rd) begin
          bus.fifo_data <= w;
          popped_cnt    <= popped_cnt + 1;
        end else begin
          bus.fifo_data <= DSIZE'($urandom);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DSIZE-1:0] w8 [8];
    logic [DSIZE-1:0] w4 [4];
    int               base;
    in_resetn     = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_flush  = 1'b0;
    #1 in_resetn  = 1'b0;

    // Reset held with an empty FIFO.
    repeat (10) begin
      @(negedge rdclk);
      #1;
      check("rst_hold_data", 64'(bus.out_data), 64'd0);
      check("rst_hold_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    end
    @(negedge rdclk);
    in_resetn = 1'b1;
    cycles(3);

    // Three words with a ready sink: latency and order.
    @(negedge rdclk);
    bus.out_ready = 1'b1;
    push(32'h11);
    push(32'h22);
    push(32'h33);
    #3 check("lat_rd_c0", 64'(bus.fifo_rd_en), 64'd1);
    @(negedge rdclk);
    #3 check("lat_valid_c1", 64'(bus.out_valid), 64'd0);
    @(negedge rdclk);
    #3 check("lat_valid_c2", 64'(bus.out_valid), 64'd1);
    check("lat_data_c2", 64'(bus.out_data), 64'h11);
    @(negedge rdclk);
    #3 check("seq_data_c3", 64'(bus.out_data), 64'h22);
    @(negedge rdclk);
    #3 check("seq_data_c4", 64'(bus.out_data), 64'h33);
    @(negedge rdclk);
    #3 check("seq_count3", 64'(bus.out_count), 64'd3);
    check("seq_occ0", 64'(bus.out_occ), 64'd0);

    // Backpressure: 8 words, sink stalled, then released.
    @(negedge rdclk);
    bus.out_ready = 1'b0;
    base = popped_cnt;
    for (int i = 0; i < 8; i++) begin
      w8[i] = DSIZE'($urandom);
      push(w8[i]);
    end
    cycles(6);
    #3 check("bp_reads", 64'(popped_cnt - base), 64'd2);
    check("bp_occ", 64'(bus.out_occ), 64'd2);
    check("bp_head", 64'(bus.out_data), 64'(w8[0]));
    check("bp_rd_idle", 64'(bus.fifo_rd_en), 64'd0);
    @(negedge rdclk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3;
      check("bp_drain_valid", 64'(bus.out_valid), 64'd1);
      check("bp_drain_data", 64'(bus.out_data), 64'(w8[i]));
      @(negedge rdclk);
    end

    // Random sink readiness and random FIFO fill.
    for (int i = 0; i < 1000; ) begin
      @(negedge rdclk);
      bus.out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        push(DSIZE'($urandom));
        i++;
      end
    end
    drain("rand");

    // Flush with a full buffer and a pop in the flush cycle.
    @(negedge rdclk);
    bus.out_ready = 1'b0;
    base = popped_cnt;
    for (int i = 0; i < 4; i++) begin
      w4[i] = DSIZE'($urandom);
      push(w4[i]);
    end
    cycles(3);
    #3 check("fl_occ2", 64'(bus.out_occ), 64'd2);
    check("fl_reads", 64'(popped_cnt - base), 64'd2);
    @(negedge rdclk);
    bus.in_flush  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge rdclk);
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b0;
    #3 check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_occ", 64'(bus.out_occ), 64'd0);
    cycles(2);
    #3 check("fl_resume_valid", 64'(bus.out_valid), 64'd1);
    check("fl_resume_data", 64'(bus.out_data), 64'(w4[2]));
    drain("fl");

    // Flush with one word buffered and one read in flight.
    @(negedge rdclk);
    bus.out_ready = 1'b0;
    base = popped_cnt;
    push(DSIZE'($urandom));
    push(DSIZE'($urandom));
    cycles(2);
    bus.in_flush = 1'b1;
    #3 check("fl2_occ1", 64'(bus.out_occ), 64'd1);
    check("fl2_reads", 64'(popped_cnt - base), 64'd2);
    @(negedge rdclk);
    bus.in_flush = 1'b0;
    #3 check("fl2_valid", 64'(bus.out_valid), 64'd0);
    check("fl2_occ", 64'(bus.out_occ), 64'd0);
    @(negedge rdclk);
    #3 check("fl2_inflight_dropped", 64'(bus.out_valid), 64'd0);

    // Counter wrap: from reset, 20 words on a 4-bit counter leave 4.
    @(negedge rdclk);
    in_resetn = 1'b0;
    cycles(2);
    in_resetn = 1'b1;
    for (int i = 0; i < 20; i++) push(DSIZE'($urandom));
    drain("wrap");
    check("wrap_count", 64'(bus.out_count), 64'd4);

    // Reset mid-stream clears every output without waiting for a clock.
    @(negedge rdclk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DSIZE'($urandom));
    cycles(4);
    bus.out_ready = 1'b1;
    cycles(1);
    in_resetn = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_data", 64'(bus.out_data), 64'd0);
    check("arst_occ", 64'(bus.out_occ), 64'd0);
    check("arst_count", 64'(bus.out_count), 64'd0);
    check("arst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    cycles(2);
    in_resetn = 1'b1;
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
